// File: rtl/led_pkg.sv
// Shared encodings for the LED display core: display modes and sweep FSM states.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_BIN   = 2'd0,
      MODE_BAR   = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_SWEEP = 2'd3
   } mode_t;

   typedef enum logic {
      SWEEP_UP   = 1'b0,
      SWEEP_DOWN = 1'b1
   } sweep_t;

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter with duty compare; all-ones brightness means always on.
module led_pwm #(
   parameter int PWM_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] brightness,
   output logic                pwm_on
);

   logic [PWM_BITS-1:0] pwm_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_cnt <= '0;
      else        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
   end

   // Plain compare can never reach 100% duty, so full-scale is special-cased.
   always_comb pwm_on = (&brightness) || (pwm_cnt < brightness);

endmodule

// File: rtl/led_display_core.sv
// LED display core: captures a value and mode, renders binary/bar/blink/sweep patterns
// gated by a global PWM brightness.
//
//  state      | meaning
//  SWEEP_UP   | sweep position moves toward LED_COUNT-1 on each step tick
//  SWEEP_DOWN | sweep position moves toward 0 on each step tick
module led_display_core
   import led_pkg::*;
#(
   parameter int INPUT_WIDTH = 32,
   parameter int LED_COUNT   = 8,
   parameter int PWM_BITS    = 4,
   parameter int STEP_DIV    = 1000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [INPUT_WIDTH-1:0] num_in,
   input  logic [1:0]             mode,
   input  logic [PWM_BITS-1:0]    brightness,
   output logic [LED_COUNT-1:0]   led_out,
   output logic                   overflow
);

   localparam int POS_W  = $clog2(LED_COUNT);
   localparam int STEP_W = $clog2(STEP_DIV);
   localparam int CMP_W  = (INPUT_WIDTH > 6) ? INPUT_WIDTH : 6;
   localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(LED_COUNT - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

   logic [INPUT_WIDTH-1:0] num_q;
   mode_t                  mode_q;
   mode_t                  mode_eff;
   logic [STEP_W-1:0]      step_cnt;
   logic                   tick;
   logic                   blink_ph;
   logic                   enter_sweep;
   sweep_t                 state, state_n;
   logic [POS_W-1:0]       pos, pos_n;
   logic                   pwm_on;
   logic [CMP_W-1:0]       num_cmp;
   logic                   over;
   logic [LED_COUNT-1:0]   bar;
   logic [LED_COUNT-1:0]   pattern;

   led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
      .clk        (clk),
      .rst_n      (rst_n),
      .brightness (brightness),
      .pwm_on     (pwm_on)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q  <= '0;
         mode_q <= MODE_BIN;
      end else if (enable) begin
         num_q  <= num_in;
         mode_q <= mode_t'(mode);
      end
   end

   assign tick        = (step_cnt == STEP_LAST);
   assign mode_eff    = enable ? mode_t'(mode) : mode_q;
   assign enter_sweep = enable && (mode_t'(mode) == MODE_SWEEP) && (mode_q != MODE_SWEEP);

   // Entering sweep restarts the step timer so the first position gets a full step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt <= '0;
         blink_ph <= 1'b0;
      end else begin
         if (enter_sweep || tick) step_cnt <= '0;
         else                     step_cnt <= step_cnt + STEP_W'(1);
         if (tick) blink_ph <= ~blink_ph;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SWEEP_UP;
         pos   <= '0;
      end else begin
         state <= state_n;
         pos   <= pos_n;
      end
   end

   always_comb begin
      state_n = state;
      pos_n   = pos;
      if (enter_sweep) begin
         state_n = SWEEP_UP;
         pos_n   = '0;
      end else if (tick && (mode_eff == MODE_SWEEP)) begin
         case (state)
            SWEEP_UP: begin
               if (pos == POS_LAST) begin
                  state_n = SWEEP_DOWN;
                  pos_n   = pos - POS_W'(1);
               end else begin
                  pos_n   = pos + POS_W'(1);
               end
            end
            default: begin
               if (pos == '0) begin
                  state_n = SWEEP_UP;
                  pos_n   = pos + POS_W'(1);
               end else begin
                  pos_n   = pos - POS_W'(1);
               end
            end
         endcase
      end
   end

   // Compare at a width that holds both the full input and LED_COUNT, so huge values never wrap.
   assign num_cmp = CMP_W'(num_q);
   assign over    = (num_cmp > CMP_W'(LED_COUNT));

   always_comb begin
      bar = '0;
      for (int i = 0; i < LED_COUNT; i++) bar[i] = (num_cmp > CMP_W'(i));
   end

   always_comb begin
      pattern = '0;
      case (mode_q)
         MODE_BIN:   pattern = LED_COUNT'(num_q);
         MODE_BAR:   pattern = bar;
         MODE_BLINK: pattern = over ? {LED_COUNT{blink_ph}} : bar;
         MODE_SWEEP: pattern = LED_COUNT'(1) << pos;
         default:    pattern = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_out  <= '0;
         overflow <= 1'b0;
      end else begin
         led_out  <= pwm_on ? pattern : '0;
         overflow <= over && ((mode_q == MODE_BAR) || (mode_q == MODE_BLINK));
      end
   end

endmodule

// File: tb/tb_led_display_core.sv
// Scoreboard bench for led_display_core with LED_COUNT=8, PWM_BITS=4, STEP_DIV=4.
module tb_led_display_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] num_in = '0;
   logic [1:0]  mode = '0;
   logic [3:0]  brightness = 4'hF;
   logic [7:0]  led_out;
   logic        overflow;

   typedef struct {
      logic [7:0] led;
      logic       ovf;
      int         tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   bit   done = 1'b0;

   led_display_core #(
      .INPUT_WIDTH (32),
      .LED_COUNT   (8),
      .PWM_BITS    (4),
      .STEP_DIV    (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .num_in     (num_in),
      .mode       (mode),
      .brightness (brightness),
      .led_out    (led_out),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Monitor: every registered output update is compared against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (led_out !== e.led || overflow !== e.ovf) begin
               failures++;
               $display("FAIL vec tag=%0d led_out=%02h overflow=%0b expected led_out=%02h overflow=%0b",
                        e.tag, led_out, overflow, e.led, e.ovf);
            end
         end
      end
   end

   // Drive the inputs seen by the next edge and queue the led_out/overflow expected after it.
   task automatic cyc(input logic en, input logic [31:0] n, input logic [1:0] m,
                      input logic [3:0] b, input logic [7:0] el, input logic eo, input int tag);
      @(negedge clk);
      enable     = en;
      num_in     = n;
      mode       = m;
      brightness = b;
      sb.push_back('{led: el, ovf: eo, tag: tag});
   endtask

   // Assert reset away from the edge and check outputs clear without a clock; release so
   // that the next cyc() call drives the first edge after reset.
   task automatic do_reset(input int tag);
      @(negedge clk);
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      checks++;
      if (led_out !== 8'h00 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL async_reset tag=%0d led_out=%02h overflow=%0b expected led_out=00 overflow=0",
                  tag, led_out, overflow);
      end
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL watchdog timeout checks=%0d", checks);
         $fatal(1, "watchdog");
      end
   end

   initial begin
      int p;
      int ps;
      #2;
      do_reset(0);

      // Binary mode: upper bits ignored, enable=0 holds.
      cyc(1, 200, 0, 15, 8'h00, 0, 101);
      cyc(1, 300, 0, 15, 8'hC8, 0, 102);
      cyc(0,   1, 0, 15, 8'h2C, 0, 103);
      cyc(0,   1, 0, 15, 8'h2C, 0, 104);
      do_reset(1);

      // Bar mode, boundaries at LED_COUNT and at the top of the input range.
      cyc(1, 3,            1, 15, 8'h00, 0, 201);
      cyc(1, 8,            1, 15, 8'h07, 0, 202);
      cyc(1, 9,            1, 15, 8'hFF, 0, 203);
      cyc(1, 0,            1, 15, 8'hFF, 1, 204);
      cyc(1, 32'hFFFFFFFF, 1, 15, 8'h00, 0, 205);
      cyc(1, 0,            0, 15, 8'hFF, 1, 206);
      cyc(0, 0,            0, 15, 8'h00, 0, 207);
      do_reset(2);

      // Blink mode: blink_ph first toggles at edge 4, visible from edge 5.
      cyc(1, 200, 2, 15, 8'h00, 0, 300);
      for (int e = 2; e <= 16; e++)
         cyc(0, 0, 2, 15, (((e - 1) / 4) % 2 == 1) ? 8'hFF : 8'h00, 1, 300 + e);
      cyc(1, 5, 2, 15, 8'h00, 1, 317);
      for (int e = 18; e <= 25; e++)
         cyc(0, 0, 2, 15, 8'h1F, 0, 300 + e);
      do_reset(3);

      // Sweep: 0x01 up to 0x80 and back, each position held 4 edges.
      cyc(1, 0, 3, 15, 8'h00, 0, 400);
      for (int e = 2; e <= 61; e++) begin
         p  = ((e - 2) / 4) % 14;
         ps = (p <= 7) ? p : 14 - p;
         cyc(0, 0, 3, 15, 8'(1 << ps), 0, 400 + e);
      end
      do_reset(4);
      for (int e = 1; e <= 3; e++)
         cyc(0, 0, 3, 15, 8'h00, 0, 470 + e);
      do_reset(5);

      // PWM: brightness 4 gives 4 of 16 cycles on; brightness 0 is dark.
      cyc(1, 8, 1, 4, 8'h00, 0, 500);
      for (int e = 2; e <= 33; e++)
         cyc(0, 0, 1, 4, (((e - 1) % 16) < 4) ? 8'hFF : 8'h00, 0, 500 + e);
      for (int e = 34; e <= 49; e++)
         cyc(0, 0, 1, 0, 8'h00, 0, 500 + e);
      do_reset(6);

      // Capture into sweep on the same edge as a step tick.
      cyc(1, 0, 1, 15, 8'h00, 0, 601);
      cyc(0, 0, 1, 15, 8'h00, 0, 602);
      cyc(0, 0, 1, 15, 8'h00, 0, 603);
      cyc(1, 0, 3, 15, 8'h00, 0, 604);
      for (int e = 5; e <= 8; e++)
         cyc(0, 0, 3, 15, 8'h01, 0, 600 + e);
      cyc(0, 0, 3, 15, 8'h02, 0, 609);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain pending=%0d expected 0", sb.size());
      end
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_display_core.md
LED_DISPLAY_CORE -- requirements
Module: led_display_core

Interface
REQ-001 Parameter INPUT_WIDTH, default 32: width of num_in.
REQ-002 Parameter LED_COUNT, default 8, legal range 2..32: number of LED outputs.
REQ-003 Parameter PWM_BITS, default 4: brightness resolution.
REQ-004 Parameter STEP_DIV, default 1000000, minimum 2: clock cycles per blink half-period and per sweep step.
REQ-005 clk  input  1  single system clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 enable  input  1  capture strobe; num_in and mode are sampled on each clk edge where enable=1.
REQ-008 num_in  input  INPUT_WIDTH  unsigned value to display.
REQ-009 mode  input  2  display mode: 0 binary, 1 bar, 2 bar-with-overflow-blink, 3 sweep.
REQ-010 brightness  input  PWM_BITS  global duty, sampled every cycle.
REQ-011 led_out  output  LED_COUNT  registered LED drive, bit 0 = LED 0.
REQ-012 overflow  output  1  registered; 1 when captured value > LED_COUNT in modes 1/2.

Function
REQ-013 Edge with enable=1 SHALL load num_q<=num_in and mode_q<=mode; enable=0 SHALL hold both; display continues from held values.
REQ-014 led_out SHALL equal pattern AND pwm_on, registered; a capture at edge k SHALL be visible on led_out at edge k+1.
REQ-015 Mode 0: pattern = num_q[LED_COUNT-1:0]; upper bits ignored; overflow=0.
REQ-016 Mode 1: pattern has the lowest min(num_q, LED_COUNT) bits set; num_q=0 gives all off; overflow=(num_q>LED_COUNT).
REQ-017 Mode 2: as mode 1 when num_q<=LED_COUNT; when num_q>LED_COUNT all LEDs SHALL blink, on during blink_ph=1; overflow as mode 1.
REQ-018 Mode 3: pattern one-hot at sweep position pos; num_q ignored; overflow=0.
REQ-019 Step counter: free-running 0..STEP_DIV-1; on wrap emit 1-cycle step tick; blink_ph toggles on each tick.
REQ-020 Sweep FSM states UP, DOWN; on tick in UP: pos+1, at pos=LED_COUNT-1 move to DOWN and decrement; in DOWN: pos-1, at pos=0 move to UP and increment; no endpoint dwells (period 2*(LED_COUNT-1) ticks).
REQ-021 Sweep FSM and pos SHALL advance only in mode 3; on entering mode 3 (mode_q change) pos=0, state=UP, step counter cleared.
REQ-022 PWM counter: free-running PWM_BITS wide, wraps at 2^PWM_BITS-1 to 0; pwm_on=(pwm_cnt<brightness) except brightness=all-ones forces pwm_on=1; brightness=0 forces all LEDs off.
REQ-023 Comparisons against LED_COUNT SHALL be unsigned at INPUT_WIDTH width; values >= 2^INPUT_WIDTH-1 SHALL not wrap.
REQ-024 Simultaneous capture and step tick: new mode_q takes effect; tick applied per REQ-021 reset rule if mode changed, else normally.

Reset
REQ-025 rst_n=0 SHALL asynchronously force num_q=0, mode_q=0, led_out=0, overflow=0, pwm_cnt=0, step counter=0, blink_ph=0, pos=0, state=UP.
REQ-026 Reset deassertion SHALL be synchronised externally; first capture permitted on the first edge after release.
REQ-027 Reset mid-sweep or mid-blink SHALL restart from the REQ-025 values, no residual pattern.

Structure
REQ-028 Shared package led_pkg SHALL hold mode encodings (MODE_BIN, MODE_BAR, MODE_BLINK, MODE_SWEEP) and sweep state encodings.
REQ-029 Sub-module led_pwm (counter plus duty compare, parameter PWM_BITS) SHALL be instantiated once; remaining logic in led_display_core.

Verification (LED_COUNT=8, PWM_BITS=4, STEP_DIV=4)
REQ-030 Reset: rst_n=0 mid-operation -> led_out=0x00, overflow=0 immediately, without waiting for a clock edge.
REQ-031 Mode 0, brightness=15, enable pulse num=200 -> next edge led_out=0xC8; enable pulse num=300 -> 0x2C; enable=0, num=1 -> stays 0x2C.
REQ-032 Mode 1, brightness=15: num=3 -> 0x07; num=8 -> 0xFF, overflow=0; num=9 -> 0xFF, overflow=1; num=0 -> 0x00.
REQ-033 Mode 2, num=200 -> led_out alternates 0x00/0xFF every 4 cycles, overflow=1; num=5 -> steady 0x1F.
REQ-034 Mode 3 -> led_out sequence 0x01,0x02,...,0x80,0x40,...,0x01, each held 4 cycles, period 56 cycles.
REQ-035 Mode 1, num=8, brightness=4 -> each 16-cycle PWM period shows 0xFF for 4 cycles, 0x00 for 12; brightness=0 -> constant 0x00.
